// File: rtl/connect4_pkg.sv
// Shared types and default board geometry for the Connect-4 datapath.
package connect4_pkg;

  localparam int COLS = 7;
  localparam int ROWS = 6;

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef logic player_t;

  typedef enum logic {
    SELECT,
    WRITE
  } move_state_t;

endpackage

// File: rtl/move_controller_cursor_ctrl.sv
// Wrap-around cursor column counter driven by left/right press pulses.
module cursor_ctrl #(
  parameter int COLS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    left_pulse,
  input  logic                    right_pulse,
  output logic [$clog2(COLS)-1:0] col
);

  localparam int CWL = $clog2(COLS);
  localparam logic [CWL-1:0] LAST = CWL'(COLS - 1);

  // Cursor register: simultaneous left and right cancel out.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
    end else if (en) begin
      if (left_pulse && !right_pulse) begin
        col <= (col == '0) ? LAST : col - 1'b1;
      end else if (right_pulse && !left_pulse) begin
        col <= (col == LAST) ? '0 : col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_controller.sv
// Turn/move controller: cursor, player, column heights, move count and the
// valid/ready board write issued for each legal drop.
module move_controller #(
  parameter int COLS = connect4_pkg::COLS,
  parameter int ROWS = connect4_pkg::ROWS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    left_pulse,
  input  logic                    right_pulse,
  input  logic                    drop_pulse,
  input  logic                    new_game,
  input  logic                    game_enable,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    player,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [$clog2(COLS)-1:0] wr_col,
  output logic [$clog2(ROWS)-1:0] wr_row,
  output logic                    wr_player,
  output logic                    illegal_drop,
  output logic                    board_full
);

  import connect4_pkg::*;

  localparam int RWL   = $clog2(ROWS);
  localparam int HW    = $clog2(ROWS + 1);
  localparam int TOTAL = COLS * ROWS;
  localparam int MW    = $clog2(TOTAL + 1);

  move_state_t       state;
  player_t           player_q;
  logic [HW-1:0]     height [COLS];
  logic [MW-1:0]     move_count;
  logic              cursor_en;

  assign player = player_q;

  // Cursor moves only when a drop does not take priority this cycle.
  assign cursor_en = (state == SELECT) && game_enable && !drop_pulse;

  cursor_ctrl #(.COLS(COLS)) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .clear       (new_game),
    .en          (cursor_en),
    .left_pulse  (left_pulse),
    .right_pulse (right_pulse),
    .col         (cursor_col)
  );

  // Turn FSM, board bookkeeping and write handshake.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state        <= SELECT;
      player_q     <= 1'b0;
      move_count   <= '0;
      wr_valid     <= 1'b0;
      wr_col       <= '0;
      wr_row       <= '0;
      wr_player    <= 1'b0;
      illegal_drop <= 1'b0;
      board_full   <= 1'b0;
      for (int unsigned i = 0; i < COLS; i++) begin
        height[i] <= '0;
      end
    end else begin
      illegal_drop <= 1'b0;
      case (state)
        SELECT: begin
          if (game_enable && drop_pulse) begin
            if (height[cursor_col] == HW'(ROWS)) begin
              illegal_drop <= 1'b1;
            end else begin
              wr_col    <= cursor_col;
              wr_row    <= RWL'(height[cursor_col]);
              wr_player <= player_q;
              wr_valid  <= 1'b1;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          if (wr_ready) begin
            height[wr_col] <= height[wr_col] + 1'b1;
            move_count     <= move_count + 1'b1;
            board_full     <= (move_count + 1'b1) == MW'(TOTAL);
            player_q       <= ~player_q;
            wr_valid       <= 1'b0;
            state          <= SELECT;
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule
